// File: rtl/cpc_xmem_pkg.sv
// Shared types for the CPC bank-switched RAM expansion: memory-cycle
// state encoding, mapping-mode constants and the region-to-block map.
package cpc_xmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Mapping modes carried in the low three bits of the config register.
  localparam logic [2:0] MODE_OFF    = 3'd0;  // expansion never serves
  localparam logic [2:0] MODE_TOP    = 3'd1;  // C000 -> block 3
  localparam logic [2:0] MODE_ALL    = 3'd2;  // every region -> same-numbered block
  localparam logic [2:0] MODE_TOP_OD = 3'd3;  // C000 -> block 3, 4000 internal (A15 overdrive)

  // Result of mapping one A15:A14 region under one mode.
  typedef struct packed {
    logic       hit;    // expansion RAM serves this access
    logic [1:0] block;  // 16K block inside the selected 64K bank
    logic       od;     // access wants A15 forced high
  } map_t;

  // Region is A15:A14 of the access; modes 4..7 put block (mode-4) at 4000.
  function automatic map_t xmem_map(input logic [2:0] mode, input logic [1:0] region);
    map_t m;
    m = '{hit: 1'b0, block: 2'd0, od: 1'b0};
    case (mode)
      MODE_OFF: ;
      MODE_TOP: begin
        if (region == 2'd3) begin
          m.hit   = 1'b1;
          m.block = 2'd3;
        end
      end
      MODE_ALL: begin
        m.hit   = 1'b1;
        m.block = region;
      end
      MODE_TOP_OD: begin
        if (region == 2'd3) begin
          m.hit   = 1'b1;
          m.block = 2'd3;
        end else if (region == 2'd1) begin
          m.od = 1'b1;
        end
      end
      default: begin
        if (region == 2'd1) begin
          m.hit   = 1'b1;
          m.block = mode[1:0];
        end
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cpc_mem_cycle_fsm.sv
// Z80 memory-cycle tracker: follows MREQ*/RD*/M1*/RFSH* to decide when an
// expansion read or write is in progress, and stretches writes by HOLD_CYC
// clocks after MREQ* rises so the SRAM sees a clean write end.
module cpc_mem_cycle_fsm
  import cpc_xmem_pkg::*;
#(
  parameter int HOLD_CYC = 1
) (
  input  logic   clk,
  input  logic   reset_b,
  input  logic   mreq_b,
  input  logic   rfsh_b,
  input  logic   rd_b,
  input  logic   m1_b,
  output state_t state,
  output logic   start
);

  localparam logic [1:0] HOLD_LOAD = (HOLD_CYC > 0) ? 2'(HOLD_CYC - 1) : 2'd0;

  logic [1:0] hold_cnt;
  logic       rd_go;
  logic       wr_go;
  logic       can_start;

  // Refresh cycles never qualify, so RFSH* low keeps the machine idle.
  assign rd_go     = !mreq_b && rfsh_b && !rd_b;
  assign wr_go     = !mreq_b && rfsh_b && rd_b && m1_b;
  // A new MREQ* during the write hold abandons the hold and starts afresh.
  assign can_start = (state == ST_IDLE) || ((state == ST_HOLD) && !mreq_b);
  assign start     = can_start && (rd_go || wr_go);

  // Cycle state and hold counter.
  // NOTE: registers update with <= so every flop samples pre-edge values;
  // blocking assignments here would make ordering change the logic.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= ST_IDLE;
      hold_cnt <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_go)      state <= ST_RD;
          else if (wr_go) state <= ST_WR;
        end
        ST_RD: begin
          if (mreq_b) state <= ST_IDLE;
        end
        ST_WR: begin
          if (mreq_b) begin
            if (HOLD_CYC > 0) begin
              state    <= ST_HOLD;
              hold_cnt <= HOLD_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (!mreq_b) begin
            if (rd_go)      state <= ST_RD;
            else if (wr_go) state <= ST_WR;
            else            state <= ST_IDLE;
          end else if (hold_cnt == 2'd0) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpld_ram_xmem_ctrl.sv
// Bank-switched RAM expansion controller for the CPC. Decodes 0x7Fxx-family
// config writes into a {bank, mode} register, latches the mapping once per
// memory cycle and drives the SRAM high address, chip select and RAMDIS.
module cpld_ram_xmem_ctrl
  import cpc_xmem_pkg::*;
#(
  parameter int BANK_BITS = 3,
  parameter int HOLD_CYC  = 1,
  parameter int OVERDRIVE = 0
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [7:0]           adr,
  input  logic [7:0]           data,
  input  logic                 iorq_b,
  input  logic                 mreq_b,
  input  logic                 rfsh_b,
  input  logic                 m1_b,
  input  logic                 wr_b,
  input  logic                 rd_b,
  input  logic                 ramrd_b,
  output logic [BANK_BITS+1:0] ramadrhi,
  output logic                 ramcs_b,
  output logic                 ramoe_b,
  output logic                 ramwe_b,
  output logic                 ramdis,
  output logic                 adr15_oe,
  output logic [BANK_BITS+2:0] cfg_q
);

  // Port address bits below XB carry the inverted bank-group number.
  localparam int XB = BANK_BITS - 3;

  logic                 cfg_hit;
  logic                 cfg_hit_q;
  logic [BANK_BITS-1:0] new_bank;
  state_t               state;
  logic                 start;
  map_t                 map_now;
  logic                 exp_hit_q;
  logic                 od_q;
  logic                 active;

  assign cfg_hit = !iorq_b && !wr_b && !adr[7] && (data[7:6] == 2'b11) && (&adr[6:XB]);

  // With BANK_BITS=3 there are no group bits to pull from the port address.
  if (XB == 0) begin : g_no_group
    assign new_bank = data[5:3];
  end else begin : g_group
    assign new_bank = {~adr[XB-1:0], data[5:3]};
  end

  // Config register: capture only on the first clock of each IO write.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cfg_hit_q <= 1'b0;
      cfg_q     <= '0;
    end else begin
      cfg_hit_q <= cfg_hit;
      if (cfg_hit && !cfg_hit_q) cfg_q <= {new_bank, data[2:0]};
    end
  end

  cpc_mem_cycle_fsm #(
    .HOLD_CYC (HOLD_CYC)
  ) u_fsm (
    .clk     (clk),
    .reset_b (reset_b),
    .mreq_b  (mreq_b),
    .rfsh_b  (rfsh_b),
    .rd_b    (rd_b),
    .m1_b    (m1_b),
    .state   (state),
    .start   (start)
  );

  // Mapping uses the register value as it stood before this edge, so a
  // config write landing in the same clock only affects later cycles.
  assign map_now = xmem_map(cfg_q[2:0], adr[7:6]);

  // Map latch: frozen for the whole cycle; ramadrhi keeps its last value
  // when the expansion does not serve the access.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      exp_hit_q <= 1'b0;
      od_q      <= 1'b0;
      ramadrhi  <= '0;
    end else if (start) begin
      exp_hit_q <= map_now.hit;
      od_q      <= (OVERDRIVE != 0) && map_now.od;
      if (map_now.hit) ramadrhi <= {cfg_q[BANK_BITS+2:3], map_now.block};
    end
  end

  assign active   = (state != ST_IDLE);
  assign ramcs_b  = !(active && exp_hit_q);
  assign ramdis   = active && exp_hit_q;
  assign adr15_oe = active && od_q;
  assign ramoe_b  = ramrd_b;
  assign ramwe_b  = wr_b;

endmodule

// File: tb/tb_cpld_ram_xmem_ctrl.sv
// Directed bench: a default instance (512K, HOLD_CYC=1, no overdrive) and a
// 4MB instance (HOLD_CYC=2, overdrive on) share one Z80 bus.
`timescale 1ns/1ps
module tb_cpld_ram_xmem_ctrl;

  logic       clk = 1'b0;
  logic       reset_b;
  logic [7:0] adr, data;
  logic       iorq_b, mreq_b, rfsh_b, m1_b, wr_b, rd_b, ramrd_b;

  logic [4:0] a_ramadrhi;
  logic [5:0] a_cfg_q;
  logic       a_ramcs_b, a_ramoe_b, a_ramwe_b, a_ramdis, a_adr15_oe;
  logic [7:0] b_ramadrhi;
  logic [8:0] b_cfg_q;
  logic       b_ramcs_b, b_ramoe_b, b_ramwe_b, b_ramdis, b_adr15_oe;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  cpld_ram_xmem_ctrl #(.BANK_BITS(3), .HOLD_CYC(1), .OVERDRIVE(0)) dut_a (
    .clk(clk), .reset_b(reset_b), .adr(adr), .data(data), .iorq_b(iorq_b),
    .mreq_b(mreq_b), .rfsh_b(rfsh_b), .m1_b(m1_b), .wr_b(wr_b), .rd_b(rd_b),
    .ramrd_b(ramrd_b), .ramadrhi(a_ramadrhi), .ramcs_b(a_ramcs_b),
    .ramoe_b(a_ramoe_b), .ramwe_b(a_ramwe_b), .ramdis(a_ramdis),
    .adr15_oe(a_adr15_oe), .cfg_q(a_cfg_q)
  );

  cpld_ram_xmem_ctrl #(.BANK_BITS(6), .HOLD_CYC(2), .OVERDRIVE(1)) dut_b (
    .clk(clk), .reset_b(reset_b), .adr(adr), .data(data), .iorq_b(iorq_b),
    .mreq_b(mreq_b), .rfsh_b(rfsh_b), .m1_b(m1_b), .wr_b(wr_b), .rd_b(rd_b),
    .ramrd_b(ramrd_b), .ramadrhi(b_ramadrhi), .ramcs_b(b_ramcs_b),
    .ramoe_b(b_ramoe_b), .ramwe_b(b_ramwe_b), .ramdis(b_ramdis),
    .adr15_oe(b_adr15_oe), .cfg_q(b_cfg_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int nclk);
    adr = a; data = d; iorq_b = 1'b0; wr_b = 1'b0;
    tick(nclk);
    iorq_b = 1'b1; wr_b = 1'b1;
    tick(1);
  endtask

  task automatic mem_start(input logic [7:0] a, input logic is_rd);
    adr = a; mreq_b = 1'b0;
    if (is_rd) begin rd_b = 1'b0; ramrd_b = 1'b0; end
    else wr_b = 1'b0;
    tick(1);
  endtask

  task automatic mem_end();
    mreq_b = 1'b1; rd_b = 1'b1; ramrd_b = 1'b1; wr_b = 1'b1; iorq_b = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    iorq_b = 1'b1; mreq_b = 1'b1; rfsh_b = 1'b1; m1_b = 1'b1;
    wr_b = 1'b1; rd_b = 1'b1; ramrd_b = 1'b1; adr = 8'h00; data = 8'h00;
    reset_b = 1'b0;
    #2;
    check("rst_cfg_a",   a_cfg_q, 0);
    check("rst_cs_a",    a_ramcs_b, 1);
    check("rst_dis_a",   a_ramdis, 0);
    check("rst_od_b",    b_adr15_oe, 0);
    check("rst_adrhi_a", a_ramadrhi, 0);
    check("rst_cfg_b",   b_cfg_q, 0);
    tick(2);
    reset_b = 1'b1;
    tick(1);

    // 0xC4 to 0x7F00: bank 0, mode 4 -> 4000 served from block 0
    io_write(8'h7F, 8'hC4, 1);
    check("m4_cfg_a", a_cfg_q, 6'b000_100);
    check("m4_cfg_b", b_cfg_q, 9'b000000_100);
    mem_start(8'h40, 1'b1);
    check("m4_rd4000_cs",    a_ramcs_b, 0);
    check("m4_rd4000_dis",   a_ramdis, 1);
    check("m4_rd4000_adrhi", a_ramadrhi, 5'b00000);
    check("m4_rd4000_oe",    a_ramoe_b, 0);
    mem_end();
    check("m4_idle_cs", a_ramcs_b, 1);
    mem_start(8'h80, 1'b1);
    check("m4_rd8000_cs",  a_ramcs_b, 1);
    check("m4_rd8000_dis", a_ramdis, 0);
    mem_end();

    // 0xCA to 0x7C00: group 3 on the 4MB instance only
    io_write(8'h7C, 8'hCA, 1);
    check("x4m_cfg_b", b_cfg_q, 9'b011_001_010);
    check("x4m_cfg_a", a_cfg_q, 6'b000_100);
    mem_start(8'hC0, 1'b1);
    check("x4m_adrhi_b", b_ramadrhi, 8'b01100111);
    check("x4m_cs_b",    b_ramcs_b, 0);
    check("x4m_cs_a",    a_ramcs_b, 1);
    check("x4m_hold_a",  a_ramadrhi, 5'b00000);
    mem_end();

    // Mode 2, write 0x1234 and watch the hold stretch
    io_write(8'h7F, 8'hC2, 1);
    check("m2_cfg_a", a_cfg_q, 6'b000_010);
    mem_start(8'h12, 1'b0);
    check("wr_cs_b",    b_ramcs_b, 0);
    check("wr_adrhi_b", b_ramadrhi, 8'b00000000);
    check("wr_we_a",    a_ramwe_b, 0);
    tick(1);
    check("wr_cs2_b", b_ramcs_b, 0);
    mem_end();
    check("hold1_cs_a",    a_ramcs_b, 0);
    check("hold1_cs_b",    b_ramcs_b, 0);
    check("hold1_adrhi_b", b_ramadrhi, 8'b00000000);
    tick(1);
    check("hold2_cs_a",    a_ramcs_b, 1);
    check("hold2_cs_b",    b_ramcs_b, 0);
    check("hold2_adrhi_b", b_ramadrhi, 8'b00000000);
    tick(1);
    check("hold3_cs_b", b_ramcs_b, 1);

    // Config write overlapping a read; 3-clock IO write captures once
    mem_start(8'h80, 1'b1);
    check("ovl_adrhi_a", a_ramadrhi, 5'b00010);
    check("ovl_adrhi_b", b_ramadrhi, 8'b00000010);
    adr = 8'h7F; data = 8'hC9; iorq_b = 1'b0; wr_b = 1'b0;
    tick(1);
    check("ovl_cfg_a",       a_cfg_q, 6'b001_001);
    check("ovl_keep_adrhi",  a_ramadrhi, 5'b00010);
    check("ovl_keep_cs",     a_ramcs_b, 0);
    data = 8'hC4;
    tick(2);
    check("ovl_once_cfg_a", a_cfg_q, 6'b001_001);
    mem_end();
    check("ovl_end_cs", a_ramcs_b, 1);
    mem_start(8'hC0, 1'b1);
    check("nxt_adrhi_a", a_ramadrhi, 5'b00111);
    check("nxt_adrhi_b", b_ramadrhi, 8'b00000111);
    check("nxt_cfg_b",   b_cfg_q, 9'b000001_001);
    mem_end();

    // Refresh in mode 2 never selects the expansion
    io_write(8'h7F, 8'hC2, 1);
    adr = 8'h00; mreq_b = 1'b0; rfsh_b = 1'b0;
    tick(1);
    check("rfsh_cs_a",  a_ramcs_b, 1);
    check("rfsh_dis_a", a_ramdis, 0);
    check("rfsh_dis_b", b_ramdis, 0);
    tick(1);
    check("rfsh2_cs_b", b_ramcs_b, 1);
    mreq_b = 1'b1; rfsh_b = 1'b1;
    tick(1);

    // Reset pulse in the middle of a write
    mem_start(8'h40, 1'b0);
    check("mid_cs_a",    a_ramcs_b, 0);
    check("mid_adrhi_a", a_ramadrhi, 5'b00001);
    #3;
    reset_b = 1'b0;
    #1;
    check("midrst_cs_a",    a_ramcs_b, 1);
    check("midrst_dis_a",   a_ramdis, 0);
    check("midrst_adrhi_a", a_ramadrhi, 0);
    check("midrst_cfg_a",   a_cfg_q, 0);
    check("midrst_cs_b",    b_ramcs_b, 1);
    mreq_b = 1'b1; wr_b = 1'b1;
    tick(1);
    reset_b = 1'b1;
    tick(1);
    check("postrst_cfg_b", b_cfg_q, 0);

    // Mode 3: 4000 stays internal, overdrive only where enabled
    io_write(8'h7F, 8'hC3, 1);
    check("m3_cfg_a", a_cfg_q, 6'b000_011);
    mem_start(8'h40, 1'b1);
    check("m3_od_b",  b_adr15_oe, 1);
    check("m3_cs_b",  b_ramcs_b, 1);
    check("m3_dis_b", b_ramdis, 0);
    check("m3_od_a",  a_adr15_oe, 0);
    check("m3_cs_a",  a_ramcs_b, 1);
    mem_end();
    check("m3_od_end_b", b_adr15_oe, 0);
    mem_start(8'hC0, 1'b1);
    check("m3_c000_cs_a",    a_ramcs_b, 0);
    check("m3_c000_adrhi_a", a_ramadrhi, 5'b00011);
    check("m3_c000_od_b",    b_adr15_oe, 0);
    mem_end();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
